// File: rtl/scanout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scanout_ctrl
//  Purpose  : Line-prefetch scanout controller. Follows the beam position from
//             the llhdmi strobes, prefetches the next active line from pixel
//             memory into a ping-pong line buffer with burst reads, and
//             presents the current pixel as a registered output.
//  Ports    : i_pixclk   - pixel clock (only clock)
//             i_reset    - synchronous active-high reset
//             i_enable   - 0 blocks new fetches and forces o_pixel to 0
//             i_rd       - current pixel consumed (hcount + 1, saturating)
//             i_newline  - line-start strobe (vcount + 1, hcount = 0)
//             i_newframe - frame-start strobe (vcount = 0, hcount = 0)
//             o_pixel    - {R,G,B} of buffer[vcount[0]][hcount]
//             o_hcount   - pixel index within the line
//             o_vcount   - line index within the frame
//             o_req      - burst read request, held with o_addr until i_ack
//             o_addr     - burst start word address
//             i_ack      - request accepted this cycle
//             i_rvalid   - read data beat valid
//             i_rdata    - read data beat
//             o_underrun - sticky: a line fetch was overrun by the next one
//  Revision : 1.0 - initial release
// ============================================================================
module scanout_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BURST    = 16,
    parameter int ADDR_W   = 19
) (
    input  logic              i_pixclk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_rd,
    input  logic              i_newline,
    input  logic              i_newframe,
    output logic [23:0]       o_pixel,
    output logic [11:0]       o_hcount,
    output logic [11:0]       o_vcount,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_ack,
    input  logic              i_rvalid,
    input  logic [23:0]       i_rdata,
    output logic              o_underrun
);

    localparam int c_WORD_W = $clog2(H_ACTIVE);
    localparam int c_BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [11:0]         c_H_ACTIVE  = 12'(H_ACTIVE);
    localparam logic [11:0]         c_V_ACTIVE  = 12'(V_ACTIVE);
    localparam logic [11:0]         c_V_LAST    = 12'(V_ACTIVE - 1);
    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(H_ACTIVE - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [11:0]         r_hcount;
    logic [11:0]         r_vcount;
    logic [11:0]         w_hcount_nxt;
    logic [11:0]         w_vcount_nxt;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WORD_W-1:0] r_word;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_bank;
    logic [11:0]         r_pend_line;
    logic                r_underrun;
    logic [23:0]         r_pixel;

    logic                w_trig;
    logic [11:0]         w_trig_line;
    logic [11:0]         w_start_line;
    logic [ADDR_W-1:0]   w_start_addr;
    logic                w_beat_last;
    logic                w_word_last;
    logic                w_wr_en;

    logic [23:0]         r_buf0 [H_ACTIVE];
    logic [23:0]         r_buf1 [H_ACTIVE];

    // ------------------------------------------------------------------
    // Beam counters: newframe > newline > rd
    // ------------------------------------------------------------------
    always_comb begin
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (i_newframe) begin
            w_hcount_nxt = 12'd0;
            w_vcount_nxt = 12'd0;
        end else if (i_newline) begin
            w_hcount_nxt = 12'd0;
            w_vcount_nxt = r_vcount + 12'd1;
        end else if (i_rd && (r_hcount < c_H_ACTIVE)) begin
            w_hcount_nxt = r_hcount + 12'd1;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_hcount <= 12'd0;
            r_vcount <= 12'd0;
        end else begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch triggers. A newline prefetches the line after the one that is
    // about to be displayed, so the display bank is never the write bank.
    // ------------------------------------------------------------------
    always_comb begin
        w_trig      = 1'b0;
        w_trig_line = 12'd0;
        if (i_enable) begin
            if (i_newframe) begin
                w_trig      = 1'b1;
                w_trig_line = 12'd0;
            end else if (i_newline && (w_vcount_nxt < c_V_LAST)) begin
                w_trig      = 1'b1;
                w_trig_line = w_vcount_nxt + 12'd1;
            end
        end
    end

    // A trigger taken while draining supersedes the parked line.
    always_comb begin
        w_start_line = r_pend_line;
        if (w_trig) begin
            w_start_line = w_trig_line;
        end
    end

    assign w_start_addr = ADDR_W'(w_start_line) * ADDR_W'(H_ACTIVE);
    assign w_beat_last  = (r_beat == c_BEAT_LAST);
    assign w_word_last  = (r_word == c_WORD_LAST);
    // A beat arriving with an overrunning trigger belongs to the abandoned
    // line and is discarded along with the rest of its burst.
    assign w_wr_en      = (r_state == c_DATA) && i_rvalid && !w_trig;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_state     <= c_IDLE;
            r_addr      <= '0;
            r_word      <= '0;
            r_beat      <= '0;
            r_bank      <= 1'b0;
            r_pend_line <= 12'd0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_trig) begin
                r_pend_line <= w_trig_line;
                if (r_state != c_IDLE) begin
                    r_underrun <= 1'b1;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (w_trig) begin
                        r_state <= c_REQ;
                        r_addr  <= w_start_addr;
                        r_word  <= '0;
                        r_beat  <= '0;
                        r_bank  <= w_start_line[0];
                    end
                end

                c_REQ: begin
                    if (w_trig && i_ack) begin
                        // Memory took the request in the same cycle: its whole
                        // burst is on the way and must be drained.
                        r_state <= c_DRAIN;
                        r_beat  <= '0;
                    end else if (w_trig) begin
                        r_addr <= w_start_addr;
                        r_word <= '0;
                        r_beat <= '0;
                        r_bank <= w_start_line[0];
                    end else if (i_ack) begin
                        r_state <= c_DATA;
                        r_beat  <= '0;
                    end
                end

                c_DATA: begin
                    if (w_trig) begin
                        if (i_rvalid && w_beat_last) begin
                            r_state <= c_REQ;
                            r_addr  <= w_start_addr;
                            r_word  <= '0;
                            r_beat  <= '0;
                            r_bank  <= w_start_line[0];
                        end else begin
                            r_state <= c_DRAIN;
                            if (i_rvalid) begin
                                r_beat <= r_beat + c_BEAT_W'(1);
                            end
                        end
                    end else if (i_rvalid) begin
                        r_word <= r_word + c_WORD_W'(1);
                        r_beat <= r_beat + c_BEAT_W'(1);
                        if (w_beat_last) begin
                            r_beat <= '0;
                            if (w_word_last) begin
                                r_state <= c_IDLE;
                            end else begin
                                r_state <= c_REQ;
                                r_addr  <= r_addr + ADDR_W'(BURST);
                            end
                        end
                    end
                end

                c_DRAIN: begin
                    if (i_rvalid) begin
                        if (w_beat_last) begin
                            r_state <= c_REQ;
                            r_addr  <= w_start_addr;
                            r_word  <= '0;
                            r_beat  <= '0;
                            r_bank  <= w_start_line[0];
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong line buffers (contents are don't-care after reset)
    // ------------------------------------------------------------------
    always_ff @(posedge i_pixclk) begin
        if (w_wr_en) begin
            if (r_bank) begin
                r_buf1[r_word] <= i_rdata;
            end else begin
                r_buf0[r_word] <= i_rdata;
            end
        end
    end

    // Read with next-state counters so o_pixel lines up with o_hcount/o_vcount.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_pixel <= 24'd0;
        end else if (!i_enable || (w_hcount_nxt >= c_H_ACTIVE) ||
                     (w_vcount_nxt >= c_V_ACTIVE)) begin
            r_pixel <= 24'd0;
        end else if (w_vcount_nxt[0]) begin
            r_pixel <= r_buf1[w_hcount_nxt[c_WORD_W-1:0]];
        end else begin
            r_pixel <= r_buf0[w_hcount_nxt[c_WORD_W-1:0]];
        end
    end

    assign o_pixel    = r_pixel;
    assign o_hcount   = r_hcount;
    assign o_vcount   = r_vcount;
    assign o_req      = (r_state == c_REQ);
    assign o_addr     = r_addr;
    assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_scanout_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_scanout_ctrl
//  Purpose  : Self-checking bench for scanout_ctrl. Stimulus pushes expected
//             beam/pixel state and expected burst addresses into queues; a
//             monitor pops and compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scanout_ctrl;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int B  = 16;
    localparam int AW = 19;
    localparam int FETCH_LIMIT = 20000;

    logic          clk = 1'b0;
    logic          reset, enable, rd, newline, newframe;
    logic          ack, rvalid;
    logic [23:0]   rdata;
    logic [23:0]   o_pixel;
    logic [11:0]   o_hcount, o_vcount;
    logic          o_req, o_underrun;
    logic [AW-1:0] o_addr;

    always #5 clk = ~clk;

    scanout_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .BURST(B), .ADDR_W(AW)) dut (
        .i_pixclk  (clk),
        .i_reset   (reset),
        .i_enable  (enable),
        .i_rd      (rd),
        .i_newline (newline),
        .i_newframe(newframe),
        .o_pixel   (o_pixel),
        .o_hcount  (o_hcount),
        .o_vcount  (o_vcount),
        .o_req     (o_req),
        .o_addr    (o_addr),
        .i_ack     (ack),
        .i_rvalid  (rvalid),
        .i_rdata   (rdata),
        .o_underrun(o_underrun)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    typedef struct {
        int h;
        int v;
        int pix;    // -1: bank contents not known to the model
        bit under;
    } exp_t;

    exp_t pixq[$];
    int   addrq[$];
    exp_t mon_e;

    // ---------------- reference model state ----------------
    int m_h, m_v;
    int m_bank[2];   // which line each bank holds, -1 if unknown
    bit m_under;
    bit m_busy;      // a fetch has been triggered and not yet completed
    bit addr_chk;

    // ---------------- memory model knobs / stats ----------------
    int ack_lat, gap_lo, gap_hi;
    bit mem_busy;
    int mem_a, mem_gap;
    int req_count  = 0;
    int beat_count = 0;
    int rq0, bc0, t, n_rd;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (pixq.size() > 0) begin
            mon_e = pixq.pop_front();
            check("hcount", o_hcount, mon_e.h);
            check("vcount", o_vcount, mon_e.v);
            if (mon_e.pix >= 0) check("pixel", o_pixel, mon_e.pix);
            check("underrun", o_underrun, mon_e.under);
        end
        if (o_req && ack) begin
            req_count++;
            if (addr_chk) begin
                if (addrq.size() == 0) check("req_addr_unexpected", o_addr, -1);
                else check("req_addr", o_addr, addrq.pop_front());
            end
        end
        if (rvalid) beat_count++;
    end

    // ---------------- memory model: rdata = word address ----------------
    initial begin : mem_model
        ack = 1'b0; rvalid = 1'b0; rdata = '0; mem_busy = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (o_req && !reset) begin
                mem_busy = 1'b1;
                for (int i = 0; i < ack_lat && !reset; i++) begin @(posedge clk); #2; end
                if (o_req && !reset) begin
                    mem_a = int'(o_addr);
                    ack = 1'b1;
                    @(posedge clk); #2;
                    ack = 1'b0;
                    for (int b = 0; b < B && !reset; b++) begin
                        mem_gap = $urandom_range(gap_hi, gap_lo);
                        for (int g = 0; g < mem_gap && !reset; g++) begin @(posedge clk); #2; end
                        if (!reset) begin
                            rvalid = 1'b1;
                            rdata  = 24'(mem_a + b);
                            @(posedge clk); #2;
                            rvalid = 1'b0;
                        end
                    end
                end
                mem_busy = 1'b0;
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic int exp_pix();
        if (!enable || m_h >= H || m_v >= V) return 0;
        if (m_bank[m_v % 2] < 0) return -1;
        return m_bank[m_v % 2] * H + m_h;
    endfunction

    function automatic void push_pix(int p);
        exp_t e;
        e.h = m_h; e.v = m_v; e.pix = p; e.under = m_under;
        pixq.push_back(e);
    endfunction

    function automatic void model_step(bit r, bit nl, bit nf);
        int trig = -1;
        if (nf) begin
            m_h = 0; m_v = 0;
            if (enable) trig = 0;
        end else if (nl) begin
            m_v = (m_v + 1) % 4096; m_h = 0;
            if (enable && m_v < V - 1) trig = m_v + 1;
        end else if (r) begin
            if (m_h < H) m_h++;
        end
        if (trig >= 0) begin
            if (m_busy) m_under = 1'b1;
            m_busy = 1'b1;
            m_bank[trig % 2] = -1;
            if (addr_chk)
                for (int k = 0; k < H / B; k++) addrq.push_back(trig * H + k * B);
        end
    endfunction

    task automatic strobe(bit r, bit nl, bit nf);
        rd = r; newline = nl; newframe = nf;
        @(posedge clk); #1;
        rd = 1'b0; newline = 1'b0; newframe = 1'b0;
        model_step(r, nl, nf);
        push_pix(exp_pix());
    endtask

    task automatic rd_burst(int n);
        for (int i = 0; i < n; i++) strobe(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_fetch(int line);
        int c = 0;
        while ((addrq.size() > 0 || mem_busy || o_req) && c < FETCH_LIMIT) begin
            @(posedge clk); #1; c++;
        end
        check("fetch_completes", (c < FETCH_LIMIT), 1);
        m_bank[line % 2] = line;
        m_busy = 1'b0;
    endtask

    task automatic wait_beats(int n);
        int c = 0;
        int b0 = beat_count;
        while (beat_count < b0 + n && c < FETCH_LIMIT) begin @(posedge clk); #1; c++; end
        check("beats_arrive", (c < FETCH_LIMIT), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; enable = 1'b1; rd = 1'b0; newline = 1'b0; newframe = 1'b0;
        ack_lat = 0; gap_lo = 0; gap_hi = 0; addr_chk = 1'b1;
        m_h = 0; m_v = 0; m_bank[0] = -1; m_bank[1] = -1; m_under = 0; m_busy = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("req_reset", o_req, 0);
        check("addr_reset", o_addr, 0);
        push_pix(0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: one frame, zero-latency memory
        strobe(1'b0, 1'b0, 1'b1);
        wait_fetch(0);
        rd_burst($urandom_range(1, 30));
        for (int n = 1; n <= 5; n++) begin
            strobe(1'b0, 1'b1, 1'b0);
            wait_fetch(n + 1);
            rd_burst((n == 5) ? 17 : $urandom_range(1, 40));
        end
        check("line5_pix17", o_pixel, 5 * H + 17);
        check("no_underrun", o_underrun, 0);
        enable = 1'b0;
        rd_burst(3);
        while (m_v < 477) strobe(1'b0, 1'b1, 1'b0);
        enable = 1'b1;
        strobe(1'b0, 1'b1, 1'b0);                 // vcount 478 -> fetch line 479
        wait_fetch(479);
        strobe(1'b0, 1'b1, 1'b0);                 // vcount 479, no fetch
        rd_burst($urandom_range(5, 60));
        strobe(1'b0, 1'b1, 1'b0);                 // vcount 480 -> blank
        rd_burst(4);

        // Test 2: slower memory, 40 bursts per line
        ack_lat = 3; gap_lo = 2; gap_hi = 2;
        rq0 = req_count;
        strobe(1'b0, 1'b0, 1'b1);
        wait_fetch(0);
        check("reqs_line0", req_count - rq0, H / B);
        ack_lat = $urandom_range(0, 5); gap_lo = 0; gap_hi = 3;
        rq0 = req_count;
        strobe(1'b0, 1'b1, 1'b0);
        wait_fetch(2);
        check("reqs_line2", req_count - rq0, H / B);
        rd_burst($urandom_range(1, 20));

        // Test 4: strobe priorities
        ack_lat = 0; gap_lo = 0; gap_hi = 1;
        rd_burst(3);
        strobe(1'b0, 1'b1, 1'b1);                 // newframe wins
        wait_fetch(0);
        rd_burst($urandom_range(2, 10));
        strobe(1'b1, 1'b1, 1'b0);                 // newline wins over rd
        wait_fetch(2);
        strobe(1'b0, 1'b1, 1'b0);                 // vcount 2, displays line 2
        wait_fetch(3);

        // Test 5: hcount saturation
        rd_burst(700);

        // Test 3: slow memory -> overrun, drain, recovery
        addr_chk = 1'b0;
        ack_lat = 20; gap_lo = 0; gap_hi = 5;
        strobe(1'b0, 1'b0, 1'b1);                 // fetch line 0
        wait_beats(3);
        strobe(1'b0, 1'b1, 1'b0);                 // overrun from DATA
        rd_burst(2);
        strobe(1'b0, 1'b1, 1'b0);                 // overrun while draining
        wait_fetch(3);
        check("underrun_set", o_underrun, 1);
        strobe(1'b0, 1'b1, 1'b0);                 // vcount 3 shows line 3, fetch 4
        rd_burst($urandom_range(10, 80));
        wait_fetch(4);
        rd_burst(5);

        // Test 6: reset in the middle of DATA
        ack_lat = 4; gap_lo = 1; gap_hi = 3;
        strobe(1'b0, 1'b0, 1'b1);
        wait_beats(2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("req_after_reset", o_req, 0);
        check("addr_after_reset", o_addr, 0);
        m_h = 0; m_v = 0; m_bank[0] = -1; m_bank[1] = -1; m_under = 0; m_busy = 0;
        addrq.delete();
        push_pix(0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        addr_chk = 1'b1;
        rq0 = req_count;
        strobe(1'b0, 1'b0, 1'b1);
        wait_fetch(0);
        check("reqs_refetch", req_count - rq0, H / B);
        n_rd = $urandom_range(1, 100);
        rd_burst(n_rd);
        check("refetch_pixel", o_pixel, n_rd);

        repeat (4) @(posedge clk);
        #1;
        check("addr_queue_empty", addrq.size(), 0);
        check("pix_queue_empty", pixq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
